// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   TUSE_NONE    : Tuse encoding for "register not read by this instruction"
//   EXC_VECTOR   : exception entry address selected by pc_sel_exc
//   *_CYC_DEF    : default MDU occupancy for mult and div classes
//   MD_OP_*      : e_md_op encodings
//   raw_hazard() : Tuse/Tnew check of one producer stage against the D instr
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0]  TUSE_NONE    = 2'd3;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_4180;
  localparam int          MULT_CYC_DEF = 5;
  localparam int          DIV_CYC_DEF  = 10;
  localparam logic        MD_OP_MULT   = 1'b0;
  localparam logic        MD_OP_DIV    = 1'b1;

  // A producer with destination wa whose result is ready in tnew cycles
  // blocks the D instr if a source it reads is needed (tuse) before then.
  // $0 is hard-wired, so it never creates a dependency.
  function automatic logic raw_hazard(input logic [4:0] wa,
                                      input logic [1:0] tnew,
                                      input logic [4:0] rs,
                                      input logic [1:0] tuse_rs,
                                      input logic [4:0] rt,
                                      input logic [1:0] tuse_rt);
    logic rs_hit;
    logic rt_hit;
    rs_hit = (wa == rs) && (tuse_rs != TUSE_NONE) && (tuse_rs < tnew);
    rt_hit = (wa == rt) && (tuse_rt != TUSE_NONE) && (tuse_rt < tnew);
    return (wa != 5'd0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// MDU occupancy counter.
//   clk, reset : clock, synchronous active-high reset
//   start_i    : E instr starts an MDU operation
//   op_i       : MD_OP_MULT / MD_OP_DIV
//   kill_i     : E instr is being cancelled this cycle (start ignored)
//   busy_o     : MDU occupied, including the start cycle itself
module md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic op_i,
  input  logic kill_i,
  output logic busy_o
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          start_ok;

  assign start_ok = start_i & ~kill_i;

  // The start cycle is the first busy cycle (busy_o includes start_ok), so
  // the register holds the number of busy cycles still to come: an N-cycle
  // op loads N-1 and the count is back to zero N cycles after the start.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = (op_i == MD_OP_DIV) ? CW'(DIV_CYC - 1) : CW'(MULT_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0) | start_ok;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline (F, D, E, M, W).
// Inputs : D-stage source regs and Tuse, E/M destination regs and Tnew,
//          MDU start/op at E, exception request and eret at M.
// Outputs: en_*/clr_* for PC, F/D, D/E, E/M, M/W registers (clr inserts a
//          bubble on the next edge), PC source selects, md_busy, and a
//          free-running count of stall cycles since reset.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_wa,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       m_tnew,
  input  logic             e_md_start,
  input  logic             e_md_op,
  input  logic             exc_req,
  input  logic             m_eret,
  output logic             en_pc,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             clr_fd,
  output logic             clr_de,
  output logic             clr_em,
  output logic             clr_mw,
  output logic             pc_sel_exc,
  output logic             pc_sel_epc,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             haz_e;
  logic             haz_m;
  logic             md_stall;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // An exception cancels the (younger) E instr, so its MDU start is killed;
  // an op already running belongs to an older instr and keeps counting.
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (e_md_start),
    .op_i    (e_md_op),
    .kill_i  (exc_req),
    .busy_o  (md_busy)
  );

  assign haz_e    = raw_hazard(e_wa, e_tnew, d_rs, d_tuse_rs, d_rt, d_tuse_rt);
  assign haz_m    = raw_hazard(m_wa, m_tnew, d_rs, d_tuse_rs, d_rt, d_tuse_rt);
  assign md_stall = d_is_md & md_busy;
  assign stall    = haz_e | haz_m | md_stall;
  assign flush    = exc_req | m_eret;

  // Flush outranks stall: whatever D was waiting for is discarded anyway.
  // On a stall the D/E register stays enabled with clr set so a bubble
  // moves into E while F and D hold.
  always_comb begin
    en_pc      = 1'b1;
    en_fd      = 1'b1;
    en_de      = 1'b1;
    en_em      = 1'b1;
    en_mw      = 1'b1;
    clr_fd     = 1'b0;
    clr_de     = 1'b0;
    clr_em     = 1'b0;
    clr_mw     = 1'b0;
    pc_sel_exc = 1'b0;
    pc_sel_epc = 1'b0;
    if (reset) begin
      clr_fd = 1'b1;
      clr_de = 1'b1;
      clr_em = 1'b1;
      clr_mw = 1'b1;
    end else if (flush) begin
      clr_fd     = 1'b1;
      clr_de     = 1'b1;
      clr_em     = 1'b1;
      // The faulting M instr must not commit; an eret may reach W.
      clr_mw     = exc_req;
      pc_sel_exc = exc_req;
      pc_sel_epc = ~exc_req;
    end else if (stall) begin
      en_pc  = 1'b0;
      en_fd  = 1'b0;
      clr_de = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       d_rs, d_rt, e_wa, m_wa;
  logic [1:0]       d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic             d_is_md, e_md_start, e_md_op, exc_req, m_eret;
  logic             en_pc, en_fd, en_de, en_em, en_mw;
  logic             clr_fd, clr_de, clr_em, clr_mw;
  logic             pc_sel_exc, pc_sel_epc, md_busy;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_is_md      (d_is_md),
    .e_wa         (e_wa),
    .e_tnew       (e_tnew),
    .m_wa         (m_wa),
    .m_tnew       (m_tnew),
    .e_md_start   (e_md_start),
    .e_md_op      (e_md_op),
    .exc_req      (exc_req),
    .m_eret       (m_eret),
    .en_pc        (en_pc),
    .en_fd        (en_fd),
    .en_de        (en_de),
    .en_em        (en_em),
    .en_mw        (en_mw),
    .clr_fd       (clr_fd),
    .clr_de       (clr_de),
    .clr_em       (clr_em),
    .clr_mw       (clr_mw),
    .pc_sel_exc   (pc_sel_exc),
    .pc_sel_epc   (pc_sel_epc),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the MDU is tracked as the index of its last busy cycle, the
  // stall counter as a plain integer.
  int               cyc       = 0;
  int               busy_last = -1;
  logic [CNT_W-1:0] scnt      = '0;
  bit               mvalid    = 1'b0;

  function automatic bit hz(input logic [4:0] wa, input logic [1:0] tn);
    return (wa != 5'd0) && ((wa == d_rs && d_tuse_rs < tn) || (wa == d_rt && d_tuse_rt < tn));
  endfunction

  function automatic bit m_busy();
    return (cyc <= busy_last) || (e_md_start && !exc_req);
  endfunction

  function automatic bit m_stall();
    return hz(e_wa, e_tnew) || hz(m_wa, m_tnew) || (d_is_md && m_busy());
  endfunction

  // {en_pc,en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em,clr_mw, sel_exc,sel_epc}
  function automatic logic [10:0] m_ctrl();
    bit fl;
    fl = exc_req || m_eret;
    if (reset) return 11'b11111_1111_00;
    if (fl)    return {5'b11111, 3'b111, exc_req, exc_req, !exc_req};
    if (m_stall()) return 11'b00111_0100_00;
    return 11'b11111_0000_00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy_last <= -1;
      scnt      <= '0;
      mvalid    <= 1'b1;
    end else begin
      if (e_md_start && !exc_req)
        busy_last <= cyc + (e_md_op ? DIV_CYC : MULT_CYC) - 1;
      if (m_stall() && !(exc_req || m_eret))
        scnt <= scnt + 1'b1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mvalid || reset) begin
      check("ctrl", {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw,
                     pc_sel_exc, pc_sel_epc}, m_ctrl());
      if (!reset) begin
        check("md_busy", md_busy, m_busy());
        check("stall_cycles", stall_cycles, scnt);
      end
    end
  end

  task automatic idle();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_op = 1'b0; exc_req = 1'b0; m_eret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    #2;
    check("rst_clr", {clr_fd, clr_de, clr_em, clr_mw}, 4'hf);
    check("rst_en", {en_pc, en_fd, en_de, en_em, en_mw}, 5'h1f);
    tick();
    tick(); reset = 1'b0; #2;
    check("post_rst_cnt", stall_cycles, 0);
    check("post_rst_busy", md_busy, 0);

    // load-use through E, then resolved at M
    tick(); e_wa = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd1; #2;
    check("lu_en_pc", en_pc, 0);
    check("lu_en_fd", en_fd, 0);
    check("lu_clr_de", clr_de, 1);
    check("lu_en_de", en_de, 1);
    tick(); m_wa = 5'd1; m_tnew = 2'd1; d_rs = 5'd1; d_tuse_rs = 2'd1; #2;
    check("lu_m_nostall", en_pc, 1);
    check("lu_cnt", stall_cycles, 1);
    tick(); m_wa = 5'd1; m_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd1; #2;
    check("haz_m", en_pc, 0);
    tick(); e_wa = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd1; #2;
    check("zero_reg", en_pc, 1);
    tick(); e_wa = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd3; #2;
    check("tuse_none", en_pc, 1);
    tick(); e_wa = 5'd5; e_tnew = 2'd1; d_rt = 5'd5; d_tuse_rt = 2'd0; #2;
    check("rt_haz", en_pc, 0);
    tick(); #2;
    check("cnt3", stall_cycles, 3);

    // div: busy t..t+9, mfhi/mflo stalled t+1..t+9
    tick(); e_md_start = 1'b1; e_md_op = 1'b1; #2;
    check("div_busy_t", md_busy, 1);
    for (int k = 1; k <= 9; k++) begin
      tick(); d_is_md = 1'b1; #2;
      check("div_stall", en_pc, 0);
    end
    tick(); d_is_md = 1'b1; #2;
    check("div_done_busy", md_busy, 0);
    check("div_done_en", en_pc, 1);

    // mult: busy t..t+4
    tick(); e_md_start = 1'b1; e_md_op = 1'b0; #2;
    check("mul_busy_t", md_busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick(); d_is_md = 1'b1; #2;
      check("mul_stall", en_pc, 0);
    end
    tick(); d_is_md = 1'b1; #2;
    check("mul_done_busy", md_busy, 0);

    // exception kills a start in the same cycle; hazard present but not counted
    tick(); e_md_start = 1'b1; e_md_op = 1'b1; exc_req = 1'b1;
    e_wa = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd1; #2;
    check("exc_start_busy", md_busy, 0);
    check("exc_start_clr", {clr_fd, clr_de, clr_em, clr_mw}, 4'hf);
    check("exc_start_sel", {pc_sel_exc, pc_sel_epc}, 2'b10);
    check("exc_start_en_pc", en_pc, 1);
    tick(); #2;
    check("exc_start_busy2", md_busy, 0);
    check("exc_start_cnt", stall_cycles, 16);

    // exception at count=6 of a div: flush wins, div runs to completion
    tick(); e_md_start = 1'b1; e_md_op = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(); d_is_md = 1'b1;
    end
    tick(); exc_req = 1'b1; d_is_md = 1'b1;
    e_wa = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd1; #2;
    check("exc_div_en_pc", en_pc, 1);
    check("exc_div_clr_mw", clr_mw, 1);
    check("exc_div_busy", md_busy, 1);
    for (int k = 5; k <= 10; k++) begin
      tick(); d_is_md = 1'b1; #2;
      check("exc_div_tail_busy", md_busy, (k < 10) ? 1 : 0);
    end
    tick(); #2;
    check("exc_div_cnt", stall_cycles, 24);

    // eret alone, then eret with exception
    tick(); m_eret = 1'b1; #2;
    check("eret_clr", {clr_fd, clr_de, clr_em, clr_mw}, 4'b1110);
    check("eret_sel", {pc_sel_exc, pc_sel_epc}, 2'b01);
    tick(); m_eret = 1'b1; exc_req = 1'b1; #2;
    check("eret_exc_sel", {pc_sel_exc, pc_sel_epc}, 2'b10);
    check("eret_exc_clr_mw", clr_mw, 1);
    tick(); #2;
    check("eret_cnt", stall_cycles, 24);

    // reset in the middle of a div
    tick(); e_md_start = 1'b1; e_md_op = 1'b1;
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; #2;
    check("rst_mid_busy", md_busy, 0);
    check("rst_mid_cnt", stall_cycles, 0);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
